frac_div_pipe: RTL
==================

# frac_div_pipe

Parametrised, pipelined, unsigned restoring fraction divider with valid/ready flow control, tag passthrough and invalid-operand detection. It is the mantissa-division engine behind the FPU divide path. It accepts one operand pair per cycle and returns quotient, sticky and remainder after a fixed `STAGES`-cycle latency. The whole pipeline stalls under output backpressure.

## Interface
- `WIDTH`, 8 — operand width in bits; unsigned fixed-point fractions.
- `STAGES`, 6 — number of pipeline register stages; legal range 1..WIDTH+1.
- `TAG_W`, 4 — width of the opaque sideband tag carried alongside each operation.

- `clk` in 1 — the single clock for the block.
- `rst` in 1 — reset; synchronous, active-high.
- `in_valid` in 1 — an operand pair is presented this cycle.
- `in_ready` out 1 — the block accepts the pair this cycle.
- `num` in WIDTH — numerator (dividend).
- `den` in WIDTH — denominator (divisor).
- `in_tag` in TAG_W — sideband tag for the operation.
- `out_valid` out 1 — a result is presented.
- `out_ready` in 1 — downstream consumes the result this cycle.
- `quot` out WIDTH+1 — quotient, equal to floor(num·2^WIDTH / den).
- `rem` out WIDTH — final remainder; present only with `FRAC_DIV_REM_EN`.
- `sticky` out 1 — set when the remainder is nonzero.
- `inval` out 1 — set when `den==0` or `num>den`.
- `out_tag` out TAG_W — the tag of the result being presented.

## Operation
- **Transfer rules**
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- **Quotient size.** N = WIDTH+1 quotient bits, bit WIDTH being the integer bit. The maximum legal quotient is 2^WIDTH, reached when `num==den`.
- **Restoring recurrence.** Partial remainder r is WIDTH+1 bits.
  - Start: r = num.
  - Bit WIDTH: if r ≥ den, then q=1 and r −= den.
  - Each following bit i = WIDTH−1..0: r = 2r; if r ≥ den, then q_i=1 and r −= den.
  - The compare is done by subtracting and checking the borrow bit, then restoring on borrow.
- **Stage mapping.** Stage s (s = 0..STAGES−1) resolves quotient bits floor((STAGES−s−1)·N/STAGES) through floor((STAGES−s)·N/STAGES)−1, processing the highest bit first.
  - Each stage is combinational bit-steps followed by a register holding {valid, r, q-so-far, den, tag, inval}.
- **Invalid operands.** Detected at entry.
  - Output is forced to `quot` = all ones, `rem` = 0, `sticky` = 1, `inval` = 1.
  - The invalid operation still occupies a slot and returns in order.
- **Ordering.** Results retire strictly in acceptance order; the tag is unmodified.

## Timing
- **Reset.** While `rst` is high at a `clk` edge, all stage valid bits clear.
  - Outputs next cycle: `out_valid`=0, `quot`=0, `rem`=0, `sticky`=0, `inval`=0, `out_tag`=0.
  - `in_ready` is 1 after reset.
  - Reset mid-operation discards every in-flight operation with no output.
- **Advance.** advance = !out_valid || out_ready.
  - All stages shift only when advance is high.
  - `in_ready` = advance, which is combinational from `out_ready`.
- **Latency.** Exactly STAGES cycles from an input transfer to `out_valid` when there is no stall. Throughput is 1 operation per cycle.
- **Backpressure.** While `out_valid && !out_ready`:
  - All stage registers and outputs hold stable.
  - `in_ready`=0.
  - Bubbles are not collapsed.
- **Simultaneous events.** Input and output transfer in the same cycle are legal and lose nothing.
- **Empty pipeline.** An empty pipeline with `in_valid`=0 keeps `out_valid`=0 and accepts the next input immediately.
- **STAGES=1.** All N bit-steps form one combinational stage.

## Configuration
- **`FRAC_DIV_REM_EN` defined.**
  - The `rem` port exists.
  - The remainder is carried to the output register and driven.
- **`FRAC_DIV_REM_EN` undefined.**
  - The `rem` port is omitted.
  - The final stage keeps only its OR-reduction for `sticky`.
  - `quot`, `sticky` and `inval` are unchanged.

## Structure
- **Package `frac_div_pkg`** holds:
  - The stage-boundary function (first and last bit index for a given s, N, STAGES).
  - The struct for the stage payload {valid, r, q, den, tag, inval}.
  - The invalid-result constants.
- **Sub-module `frac_div_stage`** is the natural unit: one combinational bit-step slice parametrised by its bit range, plus its registers and enable.
  - `frac_div_pipe` generates STAGES instances of it.
  - `frac_div_pipe` also holds the advance/handshake logic and the input-validity check.

## Test plan
- WIDTH=8, STAGES=6, `num`=1, `den`=3, tag 5 → after 6 cycles `quot`=85, `rem`=1, `sticky`=1, `inval`=0, `out_tag`=5.
- `num`=200, `den`=200 → `quot`=256, `rem`=0, `sticky`=0. Also `num`=0, `den`=7 → `quot`=0, `sticky`=0.
- `den`=0 or `num`=9, `den`=4 → `quot`=511, `rem`=0, `sticky`=1, `inval`=1, returned in order between valid neighbours.
- 32 back-to-back random legal pairs with `out_ready`=1 → one result per cycle, matching a reference model, tags in order.
- `out_ready` held 0 for 10 cycles with a full pipeline → `in_ready`=0 and outputs stable. On release, all results arrive in order with no loss or duplication.
- `rst` asserted for 1 cycle with 4 operations in flight → `out_valid`=0 next cycle and no stale results afterwards. Repeat the suite with and without `FRAC_DIV_REM_EN`, and with STAGES=1 and STAGES=9.

Source files
------------

// File: rtl/frac_div_pkg.sv
// frac_div_pkg: shared types, constants and stage-boundary helpers for frac_div_pipe.
// Contents: fd_flags_t stage payload flags, invalid-result constants,
// stage_lo/stage_hi quotient-bit range of a pipeline stage.
package frac_div_pkg;

    // Control part of every stage register; the data part (r, q, den, tag)
    // is sized by the module parameters and lives beside it in the stage.
    typedef struct packed {
        logic valid;
        logic inval;
    } fd_flags_t;

    localparam logic INV_STICKY = 1'b1;
    localparam logic INV_INVAL  = 1'b1;

    // Lowest quotient bit resolved by stage s (stage 0 owns the top bits).
    function automatic int stage_lo(input int s, input int n, input int stages);
        return (stages - s - 1) * n / stages;
    endfunction

    // Highest quotient bit resolved by stage s.
    function automatic int stage_hi(input int s, input int n, input int stages);
        return (stages - s) * n / stages - 1;
    endfunction

endpackage

// File: rtl/frac_div_stage.sv
// frac_div_stage: one restoring-division slice resolving quotient bits HI..LO, then registered.
// Ports: clk, rst (sync, active-high), en (pipeline advance),
//        f/r/q/den/tag  incoming payload,
//        f_q/r_q/q_q/den_q/tag_q  registered payload.
// FULL_R=0 keeps only the OR of the final remainder (bit 0 of r_q).
module frac_div_stage
    import frac_div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int TAG_W  = 4,
    parameter int LO     = 0,
    parameter int HI     = 0,
    parameter bit FULL_R = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  fd_flags_t        f,
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH:0]   q,
    input  logic [WIDTH-1:0] den,
    input  logic [TAG_W-1:0] tag,
    output fd_flags_t        f_q,
    output logic [WIDTH:0]   r_q,
    output logic [WIDTH:0]   q_q,
    output logic [WIDTH-1:0] den_q,
    output logic [TAG_W-1:0] tag_q
);

    logic [WIDTH:0]   r_n;
    logic [WIDTH:0]   q_n;
    logic [WIDTH+1:0] diff;

    // Bit WIDTH is the integer bit and compares r unshifted; every lower bit
    // doubles r first. A borrow out of the subtraction means r < den.
    always_comb begin
        r_n  = r;
        q_n  = q;
        diff = '0;
        for (int i = HI; i >= LO; i--) begin
            r_n  = (i == WIDTH) ? r_n : r_n << 1;
            diff = {1'b0, r_n} - {2'b0, den};
            q_n  = diff[WIDTH+1] ? q_n : q_n | ((WIDTH+1)'(1) << i);
            r_n  = diff[WIDTH+1] ? r_n : diff[WIDTH:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q   <= '0;
            r_q   <= '0;
            q_q   <= '0;
            den_q <= '0;
            tag_q <= '0;
        end else if (en) begin
            f_q   <= f;
            r_q   <= FULL_R ? r_n : {{WIDTH{1'b0}}, |r_n};
            q_q   <= q_n;
            den_q <= den;
            tag_q <= tag;
        end
    end

endmodule

// File: rtl/frac_div_pipe.sv
// frac_div_pipe: pipelined unsigned restoring fraction divider, quot = floor(num*2^WIDTH/den).
// Ports: clk, rst (sync, active-high); in_valid/in_ready, num, den, in_tag;
//        out_valid/out_ready, quot, rem (only with FRAC_DIV_REM_EN), sticky, inval, out_tag.
// Option macro FRAC_DIV_REM_EN: exposes the final remainder on rem.
module frac_div_pipe
    import frac_div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 6,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   quot,
`ifdef FRAC_DIV_REM_EN
    output logic [WIDTH-1:0] rem,
`endif
    output logic             sticky,
    output logic             inval,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N = WIDTH + 1;
`ifdef FRAC_DIV_REM_EN
    localparam bit KEEP_REM = 1'b1;
`else
    localparam bit KEEP_REM = 1'b0;
`endif

    // Index 0 is the entry payload; index s+1 is the register of stage s.
    fd_flags_t        sf [STAGES+1];
    logic [WIDTH:0]   sr [STAGES+1];
    logic [WIDTH:0]   sq [STAGES+1];
    logic [WIDTH-1:0] sd [STAGES+1];
    logic [TAG_W-1:0] st [STAGES+1];
    logic             adv;

    // The whole pipe moves in lock step; a held output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign sf[0] = '{valid: in_valid, inval: (den == '0) || (num > den)};
    assign sr[0] = {1'b0, num};
    assign sq[0] = '0;
    assign sd[0] = den;
    assign st[0] = in_tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        frac_div_stage #(
            .WIDTH  (WIDTH),
            .TAG_W  (TAG_W),
            .LO     (stage_lo(s, N, STAGES)),
            .HI     (stage_hi(s, N, STAGES)),
            .FULL_R ((s < STAGES - 1) || KEEP_REM)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .f     (sf[s]),
            .r     (sr[s]),
            .q     (sq[s]),
            .den   (sd[s]),
            .tag   (st[s]),
            .f_q   (sf[s+1]),
            .r_q   (sr[s+1]),
            .q_q   (sq[s+1]),
            .den_q (sd[s+1]),
            .tag_q (st[s+1])
        );
    end

    // Invalid operands ride the pipe with garbage data and are overridden here.
    assign out_valid = sf[STAGES].valid;
    assign inval     = sf[STAGES].inval ? INV_INVAL : 1'b0;
    assign quot      = sf[STAGES].inval ? '1 : sq[STAGES];
    assign sticky    = sf[STAGES].inval ? INV_STICKY : |sr[STAGES];
    assign out_tag   = st[STAGES];
`ifdef FRAC_DIV_REM_EN
    assign rem       = sf[STAGES].inval ? '0 : sr[STAGES][WIDTH-1:0];
`endif

endmodule
